// File: rtl/dcache_pkg.sv
// Shared constants and FSM encoding for the direct-mapped write-back data cache.
package dcache_pkg;
  localparam int CACHE_INDEX_W = 6;
  localparam int CACHE_ADDR_W  = 29;
  localparam int LINE_WORDS    = 4;
  localparam int LINE_BITS     = 128;
  localparam int OFF_W         = 2;
  localparam int TAG_W         = CACHE_ADDR_W - 4 - CACHE_INDEX_W;
  localparam int LINE_ADDR_W   = CACHE_ADDR_W - 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    WAIT = 2'd3
  } state_e;
endpackage

// File: rtl/dcache_line_store.sv
// Tag/valid/dirty/data flop arrays: async read by index, byte-masked store port,
// whole-line install port, and clear of all valid/dirty bits on reset.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int INDEX_W = CACHE_INDEX_W,
  parameter int TW      = TAG_W
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [INDEX_W-1:0]     rd_idx_i,
  output logic                   rd_valid_o,
  output logic                   rd_dirty_o,
  output logic [TW-1:0]          rd_tag_o,
  output logic [LINE_BITS-1:0]   rd_line_o,
  input  logic                   wr_en_i,
  input  logic [INDEX_W-1:0]     wr_idx_i,
  input  logic [LINE_BITS/8-1:0] wr_be_i,
  input  logic [LINE_BITS-1:0]   wr_data_i,
  input  logic                   inst_en_i,
  input  logic [INDEX_W-1:0]     inst_idx_i,
  input  logic [TW-1:0]          inst_tag_i,
  input  logic [LINE_BITS-1:0]   inst_line_i
);
  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]     valid_q;
  logic [LINES-1:0]     dirty_q;
  logic [TW-1:0]        tag_q  [LINES];
  logic [LINE_BITS-1:0] data_q [LINES];
  logic [LINE_BITS-1:0] wr_bitmask;

  always_comb begin
    wr_bitmask = '0;
    for (int b = 0; b < LINE_BITS / 8; b++) begin
      wr_bitmask[8*b +: 8] = {8{wr_be_i[b]}};
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (inst_en_i) begin
      valid_q[inst_idx_i] <= 1'b1;
      dirty_q[inst_idx_i] <= 1'b0;
    end else if (wr_en_i) begin
      dirty_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag/data contents are meaningless until valid is set, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (inst_en_i) begin
      tag_q[inst_idx_i]  <= inst_tag_i;
      data_q[inst_idx_i] <= inst_line_i;
    end else if (wr_en_i) begin
      data_q[wr_idx_i] <= (data_q[wr_idx_i] & ~wr_bitmask) | (wr_data_i & wr_bitmask);
    end
  end
endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache with a single-beat
// 128-bit line request/response port toward the memory controller.
module dcache_wb
  import dcache_pkg::*;
#(
  parameter int INDEX_W = CACHE_INDEX_W,
  parameter int ADDR_W  = CACHE_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       cpu_addr,
  input  logic              cpu_re,
  input  logic [3:0]        cpu_we,
  input  logic [31:0]       cpu_din,
  output logic [31:0]       cpu_dout,
  output logic              stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_rnw,
  output logic [ADDR_W-5:0] mem_req_addr,
  output logic [127:0]      mem_req_data,
  input  logic              mem_resp_valid,
  input  logic [127:0]      mem_resp_data
);
  localparam int TW = ADDR_W - 4 - INDEX_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:2]   req_addr_q;
  logic                req_re_q;
  logic [3:0]          req_we_q;
  logic [31:0]         req_din_q;
  logic [31:0]         dout_q;

  logic [OFF_W-1:0]    off;
  logic [INDEX_W-1:0]  idx;
  logic [TW-1:0]       tag;
  logic                rd_valid, rd_dirty, active, hit, lookup_ok, wr_en, inst_en;
  logic [TW-1:0]       rd_tag;
  logic [LINE_BITS-1:0] rd_line;
  logic [31:0]         rd_word;
  logic [15:0]         wr_be;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^{cpu_addr[31:ADDR_W], cpu_addr[1:0]};

  assign off = req_addr_q[3:2];
  assign idx = req_addr_q[4+INDEX_W-1:4];
  assign tag = req_addr_q[ADDR_W-1:4+INDEX_W];

  dcache_line_store #(.INDEX_W(INDEX_W), .TW(TW)) u_store (
    .clk_i       (clk),
    .rst_i       (rst),
    .rd_idx_i    (idx),
    .rd_valid_o  (rd_valid),
    .rd_dirty_o  (rd_dirty),
    .rd_tag_o    (rd_tag),
    .rd_line_o   (rd_line),
    .wr_en_i     (wr_en),
    .wr_idx_i    (idx),
    .wr_be_i     (wr_be),
    .wr_data_i   ({LINE_WORDS{req_din_q}}),
    .inst_en_i   (inst_en),
    .inst_idx_i  (idx),
    .inst_tag_i  (tag),
    .inst_line_i (mem_resp_data)
  );

  assign active    = req_re_q | (|req_we_q);
  assign hit       = rd_valid & (rd_tag == tag);
  assign lookup_ok = (state_q == IDLE) & active & hit;
  assign stall     = (state_q != IDLE) | (active & ~hit);
  assign rd_word   = rd_line[{off, 5'b0} +: 32];
  // Read data is taken before the store merge lands, so load+store returns the old word.
  assign cpu_dout  = (lookup_ok & req_re_q) ? rd_word : dout_q;
  assign wr_en     = lookup_ok & (|req_we_q);
  assign wr_be     = 16'(req_we_q) << {off, 2'b00};
  assign mem_req_data = rd_line;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_addr_q <= '0;
      req_re_q   <= 1'b0;
      req_we_q   <= '0;
      req_din_q  <= '0;
      dout_q     <= '0;
      state_q    <= IDLE;
    end else begin
      dout_q  <= cpu_dout;
      state_q <= state_d;
      if (!stall) begin
        req_addr_q <= cpu_addr[ADDR_W-1:2];
        req_re_q   <= cpu_re;
        req_we_q   <= cpu_we;
        req_din_q  <= cpu_din;
      end
    end
  end

  // Victim line and address stay stable through WB because the index is held.
  always_comb begin
    state_d       = state_q;
    mem_req_valid = 1'b0;
    mem_req_rnw   = 1'b0;
    mem_req_addr  = {tag, idx};
    inst_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (active && !hit) state_d = (rd_valid && rd_dirty) ? WB : FILL;
      end
      WB: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {rd_tag, idx};
        if (mem_req_ready) state_d = FILL;
      end
      FILL: begin
        mem_req_valid = 1'b1;
        mem_req_rnw   = 1'b1;
        if (mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (mem_resp_valid) begin
          inst_en = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dcache_wb.sv
// Randomized bench for dcache_wb: acts as CPU and memory controller and checks every
// cycle against an abstract cache/DRAM model plus a few literal anchor values.
module tb_dcache_wb;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  cpu_addr = '0;
  logic         cpu_re = 1'b0;
  logic [3:0]   cpu_we = '0;
  logic [31:0]  cpu_din = '0;
  logic [31:0]  cpu_dout;
  logic         stall;
  logic         mem_req_valid;
  logic         mem_req_ready = 1'b0;
  logic         mem_req_rnw;
  logic [24:0]  mem_req_addr;
  logic [127:0] mem_req_data;
  logic         mem_resp_valid = 1'b0;
  logic [127:0] mem_resp_data = '0;

  always #5 clk = ~clk;

  dcache_wb dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .stall(stall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rnw(mem_req_rnw),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  int total = 0;
  int bad = 0;

  // Abstract cache contents and backing DRAM.
  logic [18:0]  mtag  [64];
  bit           mvalid[64];
  bit           mdirty[64];
  logic [127:0] mdata [64];
  logic [127:0] dram  [logic [24:0]];
  logic [31:0]  held;

  logic [24:0]  last_wb_addr, last_fill_addr;
  logic [127:0] last_wb_data;
  bit           last_miss;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
    end
    held = '0;
  endtask

  function automatic logic [127:0] dram_line(input logic [24:0] la);
    logic [127:0] l;
    if (dram.exists(la)) return dram[la];
    for (int k = 0; k < 4; k++) l[32*k +: 32] = {7'h5A, la} ^ (32'(k) * 32'h0101_0101);
    return l;
  endfunction

  task automatic drive_junk();
    cpu_addr = $urandom;
    cpu_re   = 1'($urandom);
    cpu_we   = 4'($urandom);
    cpu_din  = $urandom;
  endtask

  task automatic chk_cpu(input string nm, input bit exp_stall, input bit exp_req);
    chk({nm, " stall"}, 128'(stall), 128'(exp_stall));
    chk({nm, " dout"}, 128'(cpu_dout), 128'(held));
    chk({nm, " req_valid"}, 128'(mem_req_valid), 128'(exp_req));
  endtask

  // One memory request: ready held low for 'hold' cycles, stray responses injected.
  task automatic serve(input bit rnw, input logic [24:0] a, input logic [127:0] d, input int hold);
    for (int c = 0; c <= hold; c++) begin
      mem_req_ready  = (c == hold);
      mem_resp_valid = ($urandom_range(0, 3) == 0);
      mem_resp_data  = {$urandom, $urandom, $urandom, $urandom};
      drive_junk();
      chk_cpu(rnw ? "fill" : "wb", 1'b1, 1'b1);
      chk(rnw ? "fill rnw" : "wb rnw", 128'(mem_req_rnw), 128'(rnw));
      chk(rnw ? "fill addr" : "wb addr", 128'(mem_req_addr), 128'(a));
      if (!rnw) chk("wb data", mem_req_data, d);
      if (c == 0) begin
        if (rnw) last_fill_addr = mem_req_addr;
        else begin
          last_wb_addr = mem_req_addr;
          last_wb_data = mem_req_data;
        end
      end
      step();
    end
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
  endtask

  task automatic do_op(input logic [31:0] a, input bit re, input logic [3:0] we,
                       input logic [31:0] din, input int hold_rd, input bit rst_in_wait);
    logic [5:0]  ix;
    logic [18:0] tg;
    logic [24:0] la;
    int          o, waitc;
    la = a[28:4];
    ix = a[9:4];
    tg = a[28:10];
    o  = int'(a[3:2]);
    cpu_addr = a; cpu_re = re; cpu_we = we; cpu_din = din;
    step();
    last_miss = 1'b0;
    if (!re && we == 4'd0) begin
      chk_cpu("idle", 1'b0, 1'b0);
      return;
    end
    if (!(mvalid[ix] && mtag[ix] == tg)) begin
      last_miss = 1'b1;
      drive_junk();
      chk_cpu("miss lookup", 1'b1, 1'b0);
      step();
      if (mvalid[ix] && mdirty[ix]) begin
        serve(1'b0, {mtag[ix], ix}, mdata[ix], $urandom_range(0, 3));
        dram[{mtag[ix], ix}] = mdata[ix];
      end
      serve(1'b1, la, '0, hold_rd);
      waitc = $urandom_range(0, 3);
      for (int c = 0; c < waitc; c++) begin
        drive_junk();
        chk_cpu("wait", 1'b1, 1'b0);
        step();
      end
      if (rst_in_wait) begin
        rst = 1'b1;
        drive_junk();
        chk_cpu("wait pre-rst", 1'b1, 1'b0);
        step();
        rst = 1'b0;
        model_reset();
        cpu_re = 1'b0; cpu_we = '0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = dram_line(la);
        chk_cpu("after rst", 1'b0, 1'b0);
        step();
        mem_resp_valid = 1'b0;
        chk_cpu("late resp", 1'b0, 1'b0);
        return;
      end
      mem_resp_valid = 1'b1;
      mem_resp_data  = dram_line(la);
      drive_junk();
      chk_cpu("resp", 1'b1, 1'b0);
      step();
      mem_resp_valid = 1'b0;
      mtag[ix] = tg; mvalid[ix] = 1'b1; mdirty[ix] = 1'b0; mdata[ix] = dram_line(la);
    end
    if (re) held = mdata[ix][32*o +: 32];
    chk_cpu("hit", 1'b0, 1'b0);
    if (we != 4'd0) begin
      for (int i = 0; i < 4; i++)
        if (we[i]) mdata[ix][32*o + 8*i +: 8] = din[8*i +: 8];
      mdirty[ix] = 1'b1;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          kind;
    model_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("reset stall", 128'(stall), 128'(0));
    chk("reset req_valid", 128'(mem_req_valid), 128'(0));
    chk("reset dout", 128'(cpu_dout), 128'(0));

    dram[25'h1000001] = {32'h33333333, 32'h22222222, 32'hDEADBEEF, 32'h11111111};
    do_op(32'h10000014, 1'b1, 4'b0000, 32'h0, 0, 1'b0);
    chk("first load missed", 128'(last_miss), 128'(1));
    chk("first fill addr", 128'(last_fill_addr), 128'(25'h1000001));
    chk("first load data", 128'(cpu_dout), 128'(32'hDEADBEEF));
    do_op(32'h10000018, 1'b1, 4'b0000, 32'h0, 0, 1'b0);
    chk("same line hit", 128'(last_miss), 128'(0));
    chk("same line data", 128'(cpu_dout), 128'(32'h22222222));
    do_op(32'h10000014, 1'b0, 4'b0010, 32'h0000CC00, 0, 1'b0);
    do_op(32'h10000014, 1'b1, 4'b0000, 32'h0, 0, 1'b0);
    chk("merged load", 128'(cpu_dout), 128'(32'hDEADCCEF));
    do_op(32'h10000414, 1'b1, 4'b0000, 32'h0, 5, 1'b0);
    chk("conflict wb addr", 128'(last_wb_addr), 128'(25'h1000001));
    chk("conflict wb word1", 128'(last_wb_data[63:32]), 128'(32'hDEADCCEF));
    chk("conflict fill addr", 128'(last_fill_addr), 128'(25'h1000041));
    do_op(32'h10000824, 1'b1, 4'b0000, 32'h0, 1, 1'b1);
    chk("cpu_dout after rst", 128'(cpu_dout), 128'(0));
    do_op(32'h10000014, 1'b1, 4'b0000, 32'h0, 0, 1'b0);
    chk("reload after rst missed", 128'(last_miss), 128'(1));
    chk("written-back word", 128'(cpu_dout), 128'(32'hDEADCCEF));
    do_op(32'h10000014, 1'b1, 4'b1111, 32'h12345678, 0, 1'b0);
    chk("load+store pre-merge", 128'(cpu_dout), 128'(32'hDEADCCEF));
    do_op(32'h10000014, 1'b1, 4'b0000, 32'h0, 0, 1'b0);
    chk("load+store merged", 128'(cpu_dout), 128'(32'h12345678));

    for (int n = 0; n < 400; n++) begin
      a = $urandom;
      a[28:10] = 19'($urandom_range(0, 3) * 32'h4321);
      a[9:4]   = 6'($urandom_range(0, 3));
      kind = $urandom_range(0, 9);
      if (kind == 0)
        do_op(a, 1'b0, 4'b0000, $urandom, 0, 1'b0);
      else if (kind <= 4)
        do_op(a, 1'b1, 4'b0000, $urandom, $urandom_range(0, 4), $urandom_range(0, 40) == 0);
      else
        do_op(a, kind == 9, 4'($urandom_range(1, 15)), $urandom, $urandom_range(0, 4), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
